jlsemi_util_clkgate_ctrl: RTL and testbench
===========================================

// Module: jlsemi_util_clkgate_ctrl
//
// PURPOSE
//   Activity-based enable controller that sits directly upstream of the
//   jlsemi_util_clkgate cell and drives its clk_en_i input.
//   Runs on the free-running clock feeding the gate and watches the activity
//   request from the gated domain. On a request it opens the clock and waits
//   out the gate's enable-synchroniser latency before flagging the clock ready.
//   After a programmable idle time it closes the clock, then holds the gate
//   closed for a guard time. Also counts wake-up events for power debug.
//
// PARAMETERS
//   EN_LAT   3   cycles between clk_en_o edge and gated clock start/stop
//                (gate SYNC_STEP+1). Legal range is 1..15.
//   IDLE_W   8   width of idle_timeout_i
//   CNT_W    16  width of wake_cnt_o
//
// PORTS
//   clk_i           in   1       free-running clock (same as gate clk_i)
//   rstn_i          in   1       async active-low reset
//   req_i           in   1       activity request, level, synchronous to clk_i
//   force_on_i      in   1       keep clock on; ORed with req_i
//   idle_timeout_i  in   IDLE_W  idle cycles before gating; quasi-static
//   cnt_clr_i       in   1       sync clear of wake_cnt_o
//   clk_en_o        out  1       registered enable to clkgate clk_en_i
//   clk_rdy_o       out  1       registered; gated clock is running
//   state_o         out  3       current FSM state (encoding below)
//   wake_cnt_o      out  CNT_W   saturating count of OFF->WAKE transitions
//
// BEHAVIOUR
// - Reset
//   - Async reset, active low.
//   - State=OFF, clk_en_o=0, clk_rdy_o=0, wake_cnt_o=0.
//   - Internal delay counter=0.
// - Request and outputs
//   - act = req_i | force_on_i, sampled on each rising clk_i.
//   - All outputs are registered and decoded from the next state.
// - States (state_o encoding)
//   - OFF=0
//     - en=0, rdy=0.
//     - act=1 at edge E -> WAKE at E; the delay counter loads EN_LAT-1.
//   - WAKE=1
//     - en=1, rdy=0.
//     - Counter decrements each cycle. When it reaches 0 -> ON, so clk_rdy_o
//       rises at edge E+EN_LAT.
//     - act is ignored in WAKE; a request drop completes the wake anyway.
//   - ON=2
//     - en=1, rdy=1.
//     - act=0 at edge F with idle_timeout_i=T:
//       - T=0 -> SLEEP at F.
//       - T>0 -> IDLE at F, with the counter loaded T-1.
//   - IDLE=3
//     - en=1, rdy=1.
//     - act=1 -> ON on that edge; the counter is discarded.
//     - Counter reaches 0 with act=0 -> SLEEP.
//     - clk_en_o and clk_rdy_o fall at edge F+T.
//   - SLEEP=4
//     - en=0, rdy=0.
//     - Counter loads EN_LAT-1 on entry. When it reaches 0 -> OFF, at edge
//       F+T+EN_LAT.
//     - act is not sampled in SLEEP. A request held high wakes from OFF on
//       the next edge, so the earliest re-open is edge F+T+EN_LAT+1.
//   - Codes 5-7 are illegal and recover to OFF on the next edge.
// - Guarantees
//   - clk_en_o never toggles twice within EN_LAT cycles.
//   - clk_rdy_o is never high unless clk_en_o has been high for at least
//     EN_LAT cycles.
//   - clk_rdy_o drops on the same edge as clk_en_o.
// - Wake counter
//   - wake_cnt_o increments by 1 on each OFF->WAKE edge.
//   - It saturates at 2^CNT_W-1 and does not wrap.
//   - cnt_clr_i forces 0 and wins over a simultaneous increment.
// - Other rules
//   - Changing idle_timeout_i takes effect at the next IDLE entry only.
//   - Reset asserted mid-WAKE or mid-IDLE returns to OFF asynchronously;
//     clk_en_o drops immediately.
//
// TESTING
// - Reset, then req_i=1 at edge 10, EN_LAT=3:
//   clk_en_o=1 from edge 10, clk_rdy_o=1 from edge 13, state_o 0->1->2,
//   wake_cnt_o=1.
// - In ON, drop req_i at edge 20 with idle_timeout_i=5:
//   en and rdy fall at edge 25, state_o=4 for 25..27, OFF at edge 28.
// - In IDLE, re-raise req_i at edge 23 (T=5):
//   state ON at 23, en/rdy stay 1, wake_cnt_o unchanged.
//   Separately, with idle_timeout_i=0, drop req_i: SLEEP on the same edge.
// - Hold req_i=1 through SLEEP:
//   OFF for exactly one cycle, then WAKE; en low for exactly EN_LAT+1 cycles.
//   Separately, force_on_i=1 with req_i=0 keeps state ON indefinitely.
// - Preload wake_cnt_o to 0xFFFF via 65535 wakes:
//   another wake holds it at 0xFFFF. cnt_clr_i together with a wake edge
//   gives 0.
// - Assert rstn_i=0 during WAKE and during IDLE:
//   all outputs return to reset values without waiting for a clock edge.
//   After release, req_i=1 gives a normal wake.

Source files
------------

// File: rtl/jlsemi_util_clkgate_ctrl.sv
// Activity-based enable controller for the clock gate: opens the clock on request, waits out the
// gate's enable latency before flagging ready, closes after an idle timeout and holds a guard time.
module jlsemi_util_clkgate_ctrl #(
   parameter int EN_LAT = 3,
   parameter int IDLE_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rstn_i,
   input  logic              req_i,
   input  logic              force_on_i,
   input  logic [IDLE_W-1:0] idle_timeout_i,
   input  logic              cnt_clr_i,
   output logic              clk_en_o,
   output logic              clk_rdy_o,
   output logic [2:0]        state_o,
   output logic [CNT_W-1:0]  wake_cnt_o
);

   // The delay counter serves both the latency guard and the idle timeout.
   localparam int DLY_W = (IDLE_W > 4) ? IDLE_W : 4;
   localparam logic [DLY_W-1:0] LAT_M1 = DLY_W'(EN_LAT - 1);

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_WAKE  = 3'd1,
      ST_ON    = 3'd2,
      ST_IDLE  = 3'd3,
      ST_SLEEP = 3'd4
   } state_t;

   state_t           state_reg, state_next;
   logic [DLY_W-1:0] dly_reg, dly_next;
   logic             en_reg, en_next;
   logic             rdy_reg, rdy_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             act;
   logic             wake_inc;

   assign act      = req_i | force_on_i;
   assign wake_inc = (state_reg == ST_OFF) && act;

   always_comb begin
      state_next = state_reg;
      dly_next   = dly_reg;
      case (state_reg)
         ST_OFF: begin
            if (act) begin
               state_next = ST_WAKE;
               dly_next   = LAT_M1;
            end
         end
         ST_WAKE: begin
            if (dly_reg == '0) state_next = ST_ON;
            else               dly_next   = dly_reg - 1'b1;
         end
         ST_ON: begin
            if (!act) begin
               if (idle_timeout_i == '0) begin
                  state_next = ST_SLEEP;
                  dly_next   = LAT_M1;
               end else begin
                  state_next = ST_IDLE;
                  dly_next   = DLY_W'(idle_timeout_i) - DLY_W'(1);
               end
            end
         end
         ST_IDLE: begin
            if (act) begin
               state_next = ST_ON;
            end else if (dly_reg == '0) begin
               state_next = ST_SLEEP;
               dly_next   = LAT_M1;
            end else begin
               dly_next = dly_reg - 1'b1;
            end
         end
         ST_SLEEP: begin
            if (dly_reg == '0) state_next = ST_OFF;
            else               dly_next   = dly_reg - 1'b1;
         end
         default: begin
            state_next = ST_OFF;
            dly_next   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state so they switch on the same edge as the state.
   always_comb begin
      en_next  = (state_next == ST_WAKE) || (state_next == ST_ON) || (state_next == ST_IDLE);
      rdy_next = (state_next == ST_ON) || (state_next == ST_IDLE);
   end

   always_comb begin
      cnt_next = cnt_reg;
      if (cnt_clr_i)
         cnt_next = '0;
      else if (wake_inc && (cnt_reg != {CNT_W{1'b1}}))
         cnt_next = cnt_reg + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_reg <= ST_OFF;
         dly_reg   <= '0;
         en_reg    <= 1'b0;
         rdy_reg   <= 1'b0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         dly_reg   <= dly_next;
         en_reg    <= en_next;
         rdy_reg   <= rdy_next;
         cnt_reg   <= cnt_next;
      end
   end

   assign clk_en_o   = en_reg;
   assign clk_rdy_o  = rdy_reg;
   assign state_o    = state_reg;
   assign wake_cnt_o = cnt_reg;

endmodule

// File: tb/tb_jlsemi_util_clkgate_ctrl.sv
// Directed bench for the clock-gate enable controller; a second narrow-counter instance
// exercises wake counter saturation and clear.
module tb_jlsemi_util_clkgate_ctrl;

   logic        clk;
   logic        rstn;
   logic        req, force_on, cnt_clr;
   logic [7:0]  tmo;
   logic        en, rdy;
   logic [2:0]  st;
   logic [15:0] cnt;

   logic        req2, force2, clr2;
   logic [7:0]  tmo2;
   logic        en2, rdy2;
   logic [2:0]  st2;
   logic [3:0]  cnt2;

   int n_vec = 0;
   int n_err = 0;

   jlsemi_util_clkgate_ctrl #(.EN_LAT(3), .IDLE_W(8), .CNT_W(16)) dut (
      .clk_i(clk), .rstn_i(rstn), .req_i(req), .force_on_i(force_on),
      .idle_timeout_i(tmo), .cnt_clr_i(cnt_clr), .clk_en_o(en), .clk_rdy_o(rdy),
      .state_o(st), .wake_cnt_o(cnt)
   );

   jlsemi_util_clkgate_ctrl #(.EN_LAT(1), .IDLE_W(8), .CNT_W(4)) dut_sat (
      .clk_i(clk), .rstn_i(rstn), .req_i(req2), .force_on_i(force2),
      .idle_timeout_i(tmo2), .cnt_clr_i(clr2), .clk_en_o(en2), .clk_rdy_o(rdy2),
      .state_o(st2), .wake_cnt_o(cnt2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one rising edge and settle; inputs driven after this apply at the next edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      req = 1'b0; force_on = 1'b0; cnt_clr = 1'b0; tmo = 8'd0;
      req2 = 1'b0; force2 = 1'b0; clr2 = 1'b0; tmo2 = 8'd0;
      repeat (3) tick();
      n_vec++;
      if ({st, en, rdy, cnt} !== 21'd0) begin
         $display("FAIL reset_main got st=%0d en=%b rdy=%b cnt=%0d need all 0", st, en, rdy, cnt);
         n_err++;
      end
      n_vec++;
      if ({st2, en2, rdy2, cnt2} !== 9'd0) begin
         $display("FAIL reset_sat got st=%0d en=%b rdy=%b cnt=%0d need all 0", st2, en2, rdy2, cnt2);
         n_err++;
      end
      rstn = 1'b1;
      tick();
      n_vec++;
      if ({st, en, rdy} !== 5'b000_0_0) begin
         $display("FAIL idle_off got st=%0d en=%b rdy=%b need st=0 en=0 rdy=0", st, en, rdy);
         n_err++;
      end
      $display("test_reset done");
   endtask

   task automatic test_wake();
      logic [4:0] exp;
      req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp = (i < 3) ? 5'b001_1_0 : 5'b010_1_1;
         n_vec++;
         if ({st, en, rdy} !== exp) begin
            $display("FAIL wake_e%0d got st=%0d en=%b rdy=%b need st=%0d en=%b rdy=%b",
                     i, st, en, rdy, exp[4:2], exp[1], exp[0]);
            n_err++;
         end
      end
      n_vec++;
      if (cnt !== 16'd1) begin
         $display("FAIL wake_cnt got %0d need 1", cnt);
         n_err++;
      end
      $display("test_wake done");
   endtask

   task automatic test_idle_sleep();
      logic [4:0] exp;
      tmo = 8'd5;
      req = 1'b0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (i < 5)      exp = 5'b011_1_1;
         else if (i < 8) exp = 5'b100_0_0;
         else            exp = 5'b000_0_0;
         n_vec++;
         if ({st, en, rdy} !== exp) begin
            $display("FAIL idle_f+%0d got st=%0d en=%b rdy=%b need st=%0d en=%b rdy=%b",
                     i, st, en, rdy, exp[4:2], exp[1], exp[0]);
            n_err++;
         end
      end
      $display("test_idle_sleep done");
   endtask

   task automatic test_idle_rewake();
      req = 1'b1;
      repeat (4) tick();
      n_vec++;
      if ({st, cnt} !== {3'd2, 16'd2}) begin
         $display("FAIL rewake_on got st=%0d cnt=%0d need st=2 cnt=2", st, cnt);
         n_err++;
      end
      tmo = 8'd5;
      req = 1'b0;
      repeat (3) tick();
      n_vec++;
      if (st !== 3'd3) begin
         $display("FAIL rewake_idle got st=%0d need 3", st);
         n_err++;
      end
      req = 1'b1;
      tick();
      n_vec++;
      if ({st, en, rdy, cnt} !== {3'd2, 1'b1, 1'b1, 16'd2}) begin
         $display("FAIL rewake_back got st=%0d en=%b rdy=%b cnt=%0d need st=2 en=1 rdy=1 cnt=2",
                  st, en, rdy, cnt);
         n_err++;
      end
      tmo = 8'd0;
      req = 1'b0;
      tick();
      n_vec++;
      if ({st, en, rdy} !== 5'b100_0_0) begin
         $display("FAIL t0_sleep got st=%0d en=%b rdy=%b need st=4 en=0 rdy=0", st, en, rdy);
         n_err++;
      end
      repeat (3) tick();
      n_vec++;
      if (st !== 3'd0) begin
         $display("FAIL t0_off got st=%0d need 0", st);
         n_err++;
      end
      $display("test_idle_rewake done");
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_st;
      int         low_cnt;
      tmo = 8'd0;
      req = 1'b1;
      repeat (4) tick();
      req = 1'b0;
      tick();
      low_cnt = (en === 1'b0) ? 1 : 0;
      n_vec++;
      if (st !== 3'd4) begin
         $display("FAIL b2b_sleep got st=%0d need 4", st);
         n_err++;
      end
      req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         exp_st = (i < 2) ? 3'd4 : ((i == 2) ? 3'd0 : 3'd1);
         if (en === 1'b0) low_cnt++;
         n_vec++;
         if (st !== exp_st) begin
            $display("FAIL b2b_e%0d got st=%0d need %0d", i, st, exp_st);
            n_err++;
         end
      end
      n_vec++;
      if (low_cnt != 4) begin
         $display("FAIL b2b_en_low got %0d cycles need 4", low_cnt);
         n_err++;
      end
      repeat (3) tick();
      n_vec++;
      if ({st, rdy, cnt} !== {3'd2, 1'b1, 16'd4}) begin
         $display("FAIL b2b_on got st=%0d rdy=%b cnt=%0d need st=2 rdy=1 cnt=4", st, rdy, cnt);
         n_err++;
      end
      $display("test_back_to_back done");
   endtask

   task automatic test_force_on();
      int bad = 0;
      req = 1'b0;
      force_on = 1'b1;
      tmo = 8'd0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if ({st, en, rdy} !== 5'b010_1_1) bad++;
      end
      n_vec++;
      if (bad != 0) begin
         $display("FAIL force_hold got %0d cycles out of ON need 0", bad);
         n_err++;
      end
      force_on = 1'b0;
      tick();
      n_vec++;
      if (st !== 3'd4) begin
         $display("FAIL force_drop got st=%0d need 4", st);
         n_err++;
      end
      repeat (3) tick();
      n_vec++;
      if (st !== 3'd0) begin
         $display("FAIL force_off got st=%0d need 0", st);
         n_err++;
      end
      $display("test_force_on done");
   endtask

   task automatic test_async_reset();
      req = 1'b1;
      tick();
      n_vec++;
      if (st !== 3'd1) begin
         $display("FAIL ar_wake got st=%0d need 1", st);
         n_err++;
      end
      #2 rstn = 1'b0;
      #1;
      n_vec++;
      if ({st, en, rdy, cnt} !== 21'd0) begin
         $display("FAIL ar_mid_wake got st=%0d en=%b rdy=%b cnt=%0d need all 0", st, en, rdy, cnt);
         n_err++;
      end
      rstn = 1'b1;
      tick();
      n_vec++;
      if ({st, en, cnt} !== {3'd1, 1'b1, 16'd1}) begin
         $display("FAIL ar_rewake got st=%0d en=%b cnt=%0d need st=1 en=1 cnt=1", st, en, cnt);
         n_err++;
      end
      repeat (3) tick();
      tmo = 8'd5;
      req = 1'b0;
      tick();
      n_vec++;
      if (st !== 3'd3) begin
         $display("FAIL ar_idle got st=%0d need 3", st);
         n_err++;
      end
      #2 rstn = 1'b0;
      #1;
      n_vec++;
      if ({st, en, rdy, cnt} !== 21'd0) begin
         $display("FAIL ar_mid_idle got st=%0d en=%b rdy=%b cnt=%0d need all 0", st, en, rdy, cnt);
         n_err++;
      end
      rstn = 1'b1;
      req = 1'b1;
      repeat (4) tick();
      n_vec++;
      if ({st, en, rdy, cnt} !== {3'd2, 1'b1, 1'b1, 16'd1}) begin
         $display("FAIL ar_normal got st=%0d en=%b rdy=%b cnt=%0d need st=2 en=1 rdy=1 cnt=1",
                  st, en, rdy, cnt);
         n_err++;
      end
      req = 1'b0;
      tmo = 8'd0;
      repeat (4) tick();
      $display("test_async_reset done");
   endtask

   task automatic test_cnt_sat();
      logic [3:0] exp_cnt;
      for (int w = 0; w < 17; w++) begin
         req2 = 1'b1;
         tick();
         exp_cnt = (w < 15) ? 4'(w + 1) : 4'd15;
         n_vec++;
         if ({st2, cnt2} !== {3'd1, exp_cnt}) begin
            $display("FAIL sat_w%0d got st=%0d cnt=%0d need st=1 cnt=%0d", w, st2, cnt2, exp_cnt);
            n_err++;
         end
         tick();
         req2 = 1'b0;
         tick();
         tick();
      end
      req2 = 1'b1;
      clr2 = 1'b1;
      tick();
      n_vec++;
      if ({st2, cnt2} !== {3'd1, 4'd0}) begin
         $display("FAIL sat_clr got st=%0d cnt=%0d need st=1 cnt=0", st2, cnt2);
         n_err++;
      end
      clr2 = 1'b0;
      req2 = 1'b0;
      repeat (3) tick();
      $display("test_cnt_sat done");
   endtask

   initial begin
      rstn = 1'b0;
      test_reset();
      test_wake();
      test_idle_sleep();
      test_idle_rewake();
      test_back_to_back();
      test_force_on();
      test_async_reset();
      test_cnt_sat();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
